// File: rtl/uss_pkg.sv
// Shared constants and FSM state type for the USS scan controller.
package uss_pkg;

  localparam int IMG_DIM = 8;
  localparam int PIX_W   = 3;
  localparam int COORD_W = 3;
  localparam int ADDR_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2
  } state_e;

endpackage

// File: rtl/uss_img_buf.sv
// 64-entry frame buffer: one synchronous write port, one registered read port.
module uss_img_buf
  import uss_pkg::*;
#(
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Storage cells carry no reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/uss_scan_ctrl.sv
// Loads one raster frame, then sweeps every centre position to USS with hold backpressure.
module uss_scan_ctrl #(
  parameter int IMG_DIM = uss_pkg::IMG_DIM,
  parameter int PIX_W   = uss_pkg::PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             hold,
  output logic             in_ready,
  output logic             out_valid,
  output logic [PIX_W-1:0] X_in,
  output logic [2:0]       X_c,
  output logic [2:0]       Y_c,
  output logic             done
);
  import uss_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_DIM * IMG_DIM - 1);

  state_e             state_q;
  logic [ADDR_W-1:0]  wr_cnt_q;
  logic [ADDR_W-1:0]  rd_cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               done_q;
  logic [COORD_W-1:0] xc_q;
  logic [COORD_W-1:0] yc_q;

  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic               rd_en;

  // wr_cnt wraps to 0 after the last pixel, but IDLE pins the address anyway.
  assign wr_en   = in_valid && (state_q != SCAN);
  assign wr_addr = (state_q == IDLE) ? '0 : wr_cnt_q;
  assign rd_en   = (state_q == SCAN) && !hold;

  uss_img_buf #(
    .DATA_W (PIX_W)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (pix_in),
    .re    (rd_en),
    .raddr (rd_cnt_q),
    .rdata (X_in)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      xc_q        <= '0;
      yc_q        <= '0;
    end else begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            wr_cnt_q <= ADDR_W'(1);
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            wr_cnt_q <= wr_cnt_q + ADDR_W'(1);
            if (wr_cnt_q == LAST_ADDR) begin
              state_q    <= SCAN;
              rd_cnt_q   <= '0;
              in_ready_q <= 1'b0;
            end
          end
        end
        SCAN: begin
          // Under hold the coordinate registers simply keep their last value.
          if (!hold) begin
            xc_q        <= rd_cnt_q[COORD_W-1:0];
            yc_q        <= rd_cnt_q[ADDR_W-1:COORD_W];
            out_valid_q <= 1'b1;
            rd_cnt_q    <= rd_cnt_q + ADDR_W'(1);
            if (rd_cnt_q == LAST_ADDR) begin
              done_q     <= 1'b1;
              state_q    <= IDLE;
              in_ready_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign X_c       = xc_q;
  assign Y_c       = yc_q;

endmodule

// File: tb/tb_uss_scan_ctrl.sv
// Self-checking bench for uss_scan_ctrl: frame-level reference model, hold table, random traffic.
module tb_uss_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] pix_in;
  logic       hold;
  logic       in_ready;
  logic       out_valid;
  logic [2:0] X_in;
  logic [2:0] X_c;
  logic [2:0] Y_c;
  logic       done;

  uss_scan_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .pix_in    (pix_in),
    .hold      (hold),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .X_in      (X_in),
    .X_c       (X_c),
    .Y_c       (Y_c),
    .done      (done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: a frame is a list of 64 accepted pixels, then 64 issued positions.
  logic [2:0] img [64];
  int         n_loaded;
  int         scan_idx;
  bit         scanning;
  logic       exp_ready, exp_valid, exp_done;
  logic [2:0] exp_x, exp_y, exp_pix;

  int vcount;
  bit done_seen;

  typedef struct {
    logic       in_valid;
    logic [2:0] pix;
    logic       hold;
    logic       exp_valid;
    logic [2:0] exp_x;
    logic [2:0] exp_y;
    logic [2:0] exp_pix;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    n_loaded  = 0;
    scan_idx  = 0;
    scanning  = 1'b0;
    exp_ready = 1'b1;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    exp_x     = '0;
    exp_y     = '0;
    exp_pix   = '0;
  endtask

  task automatic model_update(input logic v, input logic [2:0] p, input logic h);
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    if (!scanning) begin
      if (v) begin
        img[n_loaded] = p;
        n_loaded++;
        if (n_loaded == 64) begin
          scanning = 1'b1;
          scan_idx = 0;
        end
      end
    end else if (!h) begin
      exp_x     = 3'(scan_idx % 8);
      exp_y     = 3'(scan_idx / 8);
      exp_pix   = img[scan_idx];
      exp_valid = 1'b1;
      if (scan_idx == 63) begin
        exp_done = 1'b1;
        scanning = 1'b0;
        n_loaded = 0;
      end
      scan_idx++;
    end
    exp_ready = !scanning;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".in_ready"},  int'(in_ready),  int'(exp_ready));
    chk({tag, ".out_valid"}, int'(out_valid), int'(exp_valid));
    chk({tag, ".done"},      int'(done),      int'(exp_done));
    chk({tag, ".X_c"},       int'(X_c),       int'(exp_x));
    chk({tag, ".Y_c"},       int'(Y_c),       int'(exp_y));
    chk({tag, ".X_in"},      int'(X_in),      int'(exp_pix));
  endtask

  // One clock: drive at negedge, advance model at posedge, sample at next negedge.
  task automatic cyc(input string tag, input logic v, input logic [2:0] p, input logic h);
    in_valid = v;
    pix_in   = p;
    hold     = h;
    @(posedge clk);
    model_update(v, p, h);
    @(negedge clk);
    check_all(tag);
    if (out_valid) vcount++;
    if (done) done_seen = 1'b1;
  endtask

  function automatic logic [2:0] pat(input int i);
    return 3'(((i % 8) + (i / 8)) % 8);
  endfunction

  task automatic load_pattern(input string tag);
    for (int i = 0; i < 64; i++) cyc(tag, 1'b1, pat(i), 1'b0);
  endtask

  task automatic scan_to_done(input string tag, input logic v, input logic [2:0] p);
    done_seen = 1'b0;
    for (int k = 0; k < 200 && !done_seen; k++) cyc(tag, v, p, 1'b0);
    chk({tag, ".done_reached"}, int'(done_seen), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 3'd1, 3'd1};
    tbl[1] = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 3'd1, 3'd2};
    for (int i = 2; i < 7; i++) tbl[i] = '{1'b1, 3'd7, 1'b1, 1'b0, 3'd1, 3'd1, 3'd2};
    tbl[7] = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 3'd1, 3'd3};
    tbl[8] = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 3'd1, 3'd4};

    rst = 1'b1; in_valid = 1'b0; pix_in = '0; hold = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset.in_ready", int'(in_ready), 1);
    chk("reset.out_valid", int'(out_valid), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.coords", int'({X_c, Y_c, X_in}), 0);
    rst = 1'b0;

    // Full frame without hold; hold toggled during load must be ignored.
    for (int i = 0; i < 64; i++) cyc("full_load", 1'b1, pat(i), 1'(i % 2));
    vcount = 0;
    scan_to_done("full_scan", 1'b0, 3'd0);
    chk("full.valid_count", vcount, 64);
    chk("full.last_x", int'(X_c), 7);
    chk("full.last_y", int'(Y_c), 7);

    // Gapped load: every third cycle has in_valid low with junk data.
    begin
      int i = 0;
      for (int c = 0; c < 200 && i < 64; c++) begin
        if (c % 3 == 2) cyc("gap_load", 1'b0, 3'd5, 1'b0);
        else begin
          cyc("gap_load", 1'b1, pat(i), 1'b0);
          i++;
        end
      end
    end
    vcount = 0;
    scan_to_done("gap_scan", 1'b0, 3'd0);
    chk("gap.valid_count", vcount, 64);

    // Hold for 5 cycles while (2,1) is next.
    load_pattern("hold_load");
    vcount = 0;
    done_seen = 1'b0;
    for (int k = 0; k < 8; k++) cyc("hold_pre", 1'b0, 3'd0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      cyc("hold_tbl", tbl[k].in_valid, tbl[k].pix, tbl[k].hold);
      chk($sformatf("hold_tbl[%0d].out_valid", k), int'(out_valid), int'(tbl[k].exp_valid));
      chk($sformatf("hold_tbl[%0d].X_c", k), int'(X_c), int'(tbl[k].exp_x));
      chk($sformatf("hold_tbl[%0d].Y_c", k), int'(Y_c), int'(tbl[k].exp_y));
      chk($sformatf("hold_tbl[%0d].X_in", k), int'(X_in), int'(tbl[k].exp_pix));
    end
    for (int k = 0; k < 200 && !done_seen; k++) cyc("hold_post", 1'b0, 3'd0, 1'b0);
    chk("hold.done_reached", int'(done_seen), 1);
    chk("hold.valid_count", vcount, 64);

    // Pixels offered throughout SCAN are dropped; next frame starts right after done.
    for (int i = 0; i < 64; i++) cyc("ign_load", 1'b1, 3'((i * 3 + 1) % 8), 1'b0);
    scan_to_done("ign_scan", 1'b1, 3'd7);
    for (int i = 0; i < 64; i++) cyc("b2b_load", 1'b1, 3'($urandom_range(0, 7)), 1'b0);
    vcount = 0;
    scan_to_done("b2b_scan", 1'b0, 3'd0);
    chk("b2b.valid_count", vcount, 64);

    // Asynchronous reset after position 20 has been issued.
    load_pattern("rst_load");
    for (int k = 0; k < 200 && scanning && scan_idx < 21; k++) cyc("rst_scan", 1'b0, 3'd0, 1'b0);
    chk("rst.pos20_x", int'(X_c), 4);
    chk("rst.pos20_y", int'(Y_c), 2);
    rst = 1'b1;
    #1;
    chk("rst_async.in_ready", int'(in_ready), 1);
    chk("rst_async.out_valid", int'(out_valid), 0);
    chk("rst_async.X_c", int'(X_c), 0);
    chk("rst_async.Y_c", int'(Y_c), 0);
    chk("rst_async.X_in", int'(X_in), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) cyc("post_rst_load", 1'b1, 3'($urandom_range(0, 7)), 1'b0);
    vcount = 0;
    scan_to_done("post_rst_scan", 1'b0, 3'd0);
    chk("post_rst.valid_count", vcount, 64);

    // Random traffic: gaps on load, holds on scan, junk input during scan.
    for (int k = 0; k < 900; k++)
      cyc("rand", 1'(($urandom % 4) != 0), 3'($urandom % 8), 1'(($urandom % 4) == 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uss_scan_ctrl.md
# uss_scan_ctrl

Upstream controller for the USS neighbour-selection stage. It accepts one 8×8 frame of 3-bit pixels as a serial raster stream and stores it in an internal image buffer. It then sweeps every centre position in raster order, presenting `X_in` (the stored centre pixel), `X_c` and `Y_c` to USS one position per cycle. Backpressure is supported via `hold`, and `done` marks the end of each frame.

## Interface
Parameters:
- `IMG_DIM`, 8: frame width and height in pixels; fixed at 8 so coordinates fit 3 bits.
- `PIX_W`, 3: pixel width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `pix_in` carries a valid pixel this cycle.
- `pix_in`  in  3  pixel value in raster order: row 0 first, x = 0..7 within each row.
- `hold`  in  1  downstream stall; freezes the scan while high.
- `in_ready`  out  1  block accepts pixels (IDLE or LOAD).
- `out_valid`  out  1  `X_in`/`X_c`/`Y_c` hold a new scan position this cycle.
- `X_in`  out  3  stored pixel at (`X_c`, `Y_c`); drives USS `X_in`.
- `X_c`  out  3  centre column; drives USS `X_c`.
- `Y_c`  out  3  centre row; drives USS `Y_c`.
- `done`  out  1  one-cycle pulse coincident with the last scan output (7,7).

## Operation
- FSM states: IDLE, LOAD, SCAN.
- IDLE: `in_ready`=1.
  - `in_valid`=1 writes `pix_in` to address 0, sets `wr_cnt`=1 and moves to LOAD.
- LOAD: `in_ready`=1.
  - Each `in_valid` cycle writes `buf[wr_cnt]` and increments `wr_cnt` (6-bit; address = {y,x}).
  - Cycles with `in_valid` low are ignored; there is no timeout.
  - The write at `wr_cnt`=63 moves the FSM to SCAN and clears `rd_cnt`.
- SCAN: `in_ready`=0; `in_valid` is ignored and the data dropped.
  - Each cycle with `hold`=0: outputs register `X_c`=`rd_cnt[2:0]`, `Y_c`=`rd_cnt[5:3]`, `X_in`=`buf[rd_cnt]`, and `out_valid`=1; `rd_cnt` increments.
  - When `rd_cnt`=63 is issued, `done` is registered high with it and the FSM returns to IDLE.
- Hold: while `hold`=1 in SCAN, `rd_cnt` does not advance, `out_valid`=0, and `X_in`/`X_c`/`Y_c` keep their last values.
  - `hold` is ignored outside SCAN.
- Buffer contents persist across frames and are fully overwritten by each LOAD. A buffer read never returns the value being written in the same cycle; reads occur only in SCAN, so there is no hazard.
- `out_valid` and `done` are low in every cycle other than an issued scan step.

## Timing
- Reset values: state=IDLE, `wr_cnt`=0, `rd_cnt`=0, `in_ready`=1, `out_valid`=0, `done`=0, `X_in`=0, `X_c`=0, `Y_c`=0. Buffer cells are not reset.
- Reset mid-LOAD or mid-SCAN aborts the frame immediately (asynchronous). The next frame restarts at address 0.
- Load latency: the 64th pixel accepted at edge E puts the FSM in SCAN after E.
- Scan latency, with no hold:
  - (0,0) is presented with `out_valid`=1 from edge E+1.
  - (7,7) and `done` are presented from edge E+64.
  - `in_ready` returns high after the same edge.
- A pixel offered in the first IDLE cycle after `done` is accepted as address 0 of the next frame.
- Full throughput: 64 load cycles plus 64 scan cycles per frame. The back-to-back frame period is 128 cycles.
- `hold` asserted in the cycle after E suppresses (0,0) until the first cycle with `hold`=0.

## Structure
- Package `uss_pkg` holds `IMG_DIM`, `PIX_W`, `COORD_W`=3, `ADDR_W`=6 and the FSM state enum {IDLE, LOAD, SCAN}.
- Sub-module `uss_img_buf`: 64×3 register file with one synchronous write port and one registered read port (read enable = scan step). Its read register provides `X_in`.
- The top level contains the FSM, both counters, and the `X_c`/`Y_c`/`out_valid`/`done` registers.

## Test plan
- **Reset values:** assert `rst` → all outputs 0 and `in_ready`=1.
- **Full frame, `hold`=0:** stream pixel(x,y)=(x+y)%8 for 64 cycles → 64 consecutive `out_valid` cycles, starting 1 cycle after the last load. Coordinates run (0,0),(1,0)…(7,7) with `X_in`=(x+y)%8; `done` is high only with (7,7).
- **Gapped load:** drop `in_valid` on every 3rd cycle → the same scan output as the full-frame case. While `in_valid`=0, `wr_cnt` does not advance.
- **Hold:** raise `hold` for 5 cycles while (10 = x2,y1) is next → `out_valid`=0 and outputs frozen at (1,1) for those 5 cycles, then (2,1) follows. `done` is still issued after exactly 64 valid outputs.
- **Ignored input:** drive `in_valid`=1 with `pix_in`=7 throughout SCAN → the scanned values are unchanged and the next frame loads from address 0.
- **Reset mid-scan:** pulse `rst` at scan position 20 → immediate return to IDLE with outputs 0. A new 64-pixel frame then scans correctly from (0,0).
